// File: rtl/predictor_table.sv
// Table of saturating counters predicting branch direction, with mispredict stats.
// Define PT_GSHARE_EN to hash the request index with a global history register.
module predictor_table #(
    parameter int CTR_W  = 2,
    parameter int IDX_W  = 4,
    parameter int GHR_W  = 4,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              request,
    input  logic [IDX_W-1:0]  req_idx,
    output logic              pred_valid,
    output logic              prediction,
    output logic [IDX_W-1:0]  pred_idx,
    input  logic              result,
    input  logic [IDX_W-1:0]  upd_idx,
    input  logic              taken,
    input  logic              upd_pred,
    output logic [STAT_W-1:0] mispredicts
);

    localparam int DEPTH = 1 << IDX_W;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_MAX = '1;
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    logic [CTR_W-1:0] table_q [DEPTH];
    logic [IDX_W-1:0] idx;
    logic [CTR_W-1:0] upd_ctr;
    logic [CTR_W-1:0] upd_next;
    logic             miss;

`ifdef PT_GSHARE_EN
    logic [GHR_W-1:0] ghr;

    // Old history hashes the request even when a result lands this cycle.
    assign idx = req_idx ^ IDX_W'(ghr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr <= '0;
        end else if (result) begin
            ghr <= GHR_W'({ghr, taken});
        end
    end
`else
    assign idx = req_idx;
`endif

    assign upd_ctr = table_q[upd_idx];
    assign miss    = result && (taken != upd_pred);

    always_comb begin
        upd_next = upd_ctr;
        if (taken) begin
            if (upd_ctr != CTR_MAX) upd_next = upd_ctr + 1'b1;
        end else begin
            if (upd_ctr != '0) upd_next = upd_ctr - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= CTR_INIT;
            end
        end else if (result) begin
            table_q[upd_idx] <= upd_next;
        end
    end

    // Reads the pre-update counter, so a same-cycle update is not forwarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid <= 1'b0;
            prediction <= 1'b0;
            pred_idx   <= '0;
        end else if (request) begin
            pred_valid <= 1'b1;
            prediction <= table_q[idx][CTR_W-1];
            pred_idx   <= idx;
        end else begin
            pred_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredicts <= '0;
        end else if (miss && mispredicts != STAT_MAX) begin
            mispredicts <= mispredicts + 1'b1;
        end
    end

endmodule

// File: tb/tb_predictor_table.sv
// Scoreboard bench for predictor_table: model table, queued expected predictions.
// A second instance with STAT_W=2 checks mispredict-counter saturation.
module tb_predictor_table;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       request = 1'b0;
    logic [3:0] req_idx = '0;
    logic       result = 1'b0;
    logic [3:0] upd_idx = '0;
    logic       taken = 1'b0;
    logic       upd_pred = 1'b0;

    logic        pred_valid, prediction;
    logic [3:0]  pred_idx;
    logic [15:0] mispredicts;
    logic        pred_valid2, prediction2;
    logic [3:0]  pred_idx2;
    logic [1:0]  mispredicts2;

    int checks = 0;
    int errors = 0;

    int         mtab [16];
    int         mmis;
    int         mmis2;
    logic [3:0] mghr;
    logic       last_pred;
    logic [3:0] last_idx;
    logic [4:0] exp_q [$];

    always #5 clk = ~clk;

    predictor_table dut (
        .clk(clk), .rst_n(rst_n),
        .request(request), .req_idx(req_idx),
        .pred_valid(pred_valid), .prediction(prediction), .pred_idx(pred_idx),
        .result(result), .upd_idx(upd_idx), .taken(taken), .upd_pred(upd_pred),
        .mispredicts(mispredicts)
    );

    predictor_table #(.STAT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .request(request), .req_idx(req_idx),
        .pred_valid(pred_valid2), .prediction(prediction2), .pred_idx(pred_idx2),
        .result(result), .upd_idx(upd_idx), .taken(taken), .upd_pred(upd_pred),
        .mispredicts(mispredicts2)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mtab[i] = 1;
        mmis = 0;
        mmis2 = 0;
        mghr = '0;
        last_pred = 1'b0;
        last_idx = '0;
        exp_q.delete();
    endtask

    task automatic step(input logic rq, input logic [3:0] ri,
                        input logic rs, input logic [3:0] ui,
                        input logic tk, input logic up);
        logic [3:0] hidx;
        logic [4:0] e;
        @(negedge clk);
        request = rq; req_idx = ri;
        result = rs; upd_idx = ui; taken = tk; upd_pred = up;
`ifdef PT_GSHARE_EN
        hidx = ri ^ mghr;
`else
        hidx = ri;
`endif
        if (rq) exp_q.push_back({mtab[hidx] >= 2, hidx});
        if (rs) begin
            if (tk) mtab[ui] = (mtab[ui] < 3) ? mtab[ui] + 1 : 3;
            else    mtab[ui] = (mtab[ui] > 0) ? mtab[ui] - 1 : 0;
            if (tk != up) begin
                if (mmis < 65535) mmis++;
                if (mmis2 < 3) mmis2++;
            end
            mghr = {mghr[2:0], tk};
        end
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            last_pred = e[4];
            last_idx = e[3:0];
            check("pred_valid", 32'(pred_valid), 32'd1);
        end else begin
            check("pred_valid_idle", 32'(pred_valid), 32'd0);
        end
        check("prediction", 32'(prediction), 32'(last_pred));
        check("pred_idx", 32'(pred_idx), 32'(last_idx));
        check("mispredicts", 32'(mispredicts), 32'(mmis));
        check("mispredicts_sat", 32'(mispredicts2), 32'(mmis2));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_pred_valid", 32'(pred_valid), 32'd0);
        check("rst_prediction", 32'(prediction), 32'd0);
        check("rst_pred_idx", 32'(pred_idx), 32'd0);
        check("rst_mispredicts", 32'(mispredicts), 32'd0);
        check("rst_mispredicts2", 32'(mispredicts2), 32'd0);
        request = 1'b0;
        result = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #12;
        do_reset();

        // reset state: weakly not-taken
        step(1, 4'd3, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // saturation on idx 5
        repeat (4) step(0, 0, 1, 4'd5, 1, 1);
        step(1, 4'd5, 0, 0, 0, 0);
        step(1, 4'd5, 1, 4'd5, 0, 1);
        step(1, 4'd5, 0, 0, 0, 0);
        repeat (2) step(0, 0, 1, 4'd5, 0, 0);
        step(1, 4'd5, 0, 0, 0, 0);
        repeat (5) step(0, 0, 1, 4'd5, 0, 0);
        step(1, 4'd5, 1, 4'd5, 1, 0);
        step(1, 4'd5, 1, 4'd5, 1, 0);
        step(1, 4'd5, 0, 0, 0, 0);

        // isolation
        repeat (3) step(0, 0, 1, 4'd2, 1, 1);
        step(1, 4'd7, 0, 0, 0, 0);
        step(1, 4'd2, 0, 0, 0, 0);

        // same cycle, same index: old value used
        step(1, 4'd1, 1, 4'd1, 1, 0);
        step(1, 4'd1, 0, 0, 0, 0);
        // same cycle, different index
        step(1, 4'd9, 1, 4'd8, 1, 1);
        step(1, 4'd8, 0, 0, 0, 0);

        // misprediction accounting
        step(0, 0, 1, 4'd4, 1, 0);
        step(0, 0, 1, 4'd4, 0, 0);
        step(0, 0, 1, 4'd4, 0, 1);
        step(0, 0, 1, 4'd4, 1, 1);
        step(0, 0, 1, 4'd4, 1, 0);
        repeat (3) step(0, 0, 1, 4'd6, 0, 1);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom),
                 1'($urandom), 1'($urandom));
        end

        // mid-operation reset with a prediction in flight
        repeat (3) step(0, 0, 1, 4'd12, 1, 1);
        @(negedge clk);
        request = 1'b1;
        req_idx = 4'd12;
        @(posedge clk);
        do_reset();
        step(1, 4'd12, 0, 0, 0, 0);
        step(1, 4'd2, 0, 0, 0, 0);

`ifdef PT_GSHARE_EN
        do_reset();
        step(0, 0, 1, 4'd0, 1, 1);
        step(0, 0, 1, 4'd0, 0, 0);
        step(0, 0, 1, 4'd0, 1, 1);
        step(1, 4'hF, 0, 0, 0, 0);
        check("gshare_idx", 32'(pred_idx), 32'hA);
        step(0, 0, 1, 4'd0, 1, 1);
        do_reset();
        step(1, 4'hF, 0, 0, 0, 0);
        check("gshare_rst_idx", 32'(pred_idx), 32'hF);
`endif

        step(0, 0, 0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
